// File: rtl/cc_muxseq_pkg.sv
// rtl/cc_muxseq_pkg.sv - shared state encoding, default blank value and select-width check
// Build option: CC_MUXSEQ_ERRFLAG_EN (see cc_muxseq).
package cc_muxseq_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_BLANK  = 1'b1
  } muxseq_state_t;

  localparam int MUXSEQ_DEFAULT_BLANKVALUE = 0;

  function automatic bit sel_width_ok(input int channels, input int selwidth);
    return (channels >= 2) && ((64'd1 << selwidth) >= 64'(channels));
  endfunction

endpackage

// File: rtl/cc_muxseq_counter.sv
// rtl/cc_muxseq_counter.sv - loadable down-counter with zero flag for the blanking interval
module cc_muxseq_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cc_muxseq.sv
// rtl/cc_muxseq.sv - N-channel registered pattern selector with timed blanking on channel change
// Build option: CC_MUXSEQ_ERRFLAG_EN adds a sticky bad-select flag instead of clamping.
module cc_muxseq
  import cc_muxseq_pkg::*;
#(
  parameter int MUXSEQ_CHANNELS    = 4,
  parameter int MUXSEQ_DATAWIDTH   = 8,
  parameter int MUXSEQ_SELECTWIDTH = 2,
  parameter int MUXSEQ_BLANKCYCLES = 3,
  parameter logic [MUXSEQ_DATAWIDTH-1:0] MUXSEQ_BLANKVALUE =
    MUXSEQ_DATAWIDTH'(MUXSEQ_DEFAULT_BLANKVALUE)
) (
  input  logic                                    CC_MUXSEQ_CLOCK_50,
  input  logic                                    CC_MUXSEQ_RESET_InLow,
  input  logic [MUXSEQ_CHANNELS*MUXSEQ_DATAWIDTH-1:0] CC_MUXSEQ_data_InBUS,
  input  logic [MUXSEQ_SELECTWIDTH-1:0]           CC_MUXSEQ_select_InBUS,
  input  logic                                    CC_MUXSEQ_load_In,
  output logic [MUXSEQ_DATAWIDTH-1:0]             CC_MUXSEQ_data_OutBUS,
  output logic [MUXSEQ_SELECTWIDTH-1:0]           CC_MUXSEQ_sel_OutBUS,
  output logic                                    CC_MUXSEQ_busy_Out
`ifdef CC_MUXSEQ_ERRFLAG_EN
  ,
  output logic                                    CC_MUXSEQ_error_Out
`endif
);

  localparam int DW = MUXSEQ_DATAWIDTH;
  localparam int SW = MUXSEQ_SELECTWIDTH;

  if (!sel_width_ok(MUXSEQ_CHANNELS, MUXSEQ_SELECTWIDTH)) begin : g_bad_select_width
    $error("cc_muxseq: select width cannot address all channels");
  end

  muxseq_state_t state;
  logic [SW-1:0] active;
  logic [SW-1:0] pending;
  logic [DW-1:0] data_q;
  logic          busy_q;
  logic          cnt_zero;
  logic          in_range;
  logic          req_valid;
  logic [SW-1:0] eff_sel;
  logic [SW-1:0] next_pending;

  assign in_range = (int'(CC_MUXSEQ_select_InBUS) < MUXSEQ_CHANNELS);

`ifdef CC_MUXSEQ_ERRFLAG_EN
  logic err_q;
  assign req_valid = CC_MUXSEQ_load_In && in_range;
  assign eff_sel   = CC_MUXSEQ_select_InBUS;
  assign CC_MUXSEQ_error_Out = err_q;
`else
  // Anything past the last channel lands on the last channel.
  assign req_valid = CC_MUXSEQ_load_In;
  assign eff_sel   = in_range ? CC_MUXSEQ_select_InBUS : SW'(MUXSEQ_CHANNELS - 1);
`endif

  // A request arriving on the final blank edge still wins the commit.
  assign next_pending = req_valid ? eff_sel : pending;

  function automatic logic [DW-1:0] chan(input logic [SW-1:0] idx);
    return CC_MUXSEQ_data_InBUS[int'(idx)*DW +: DW];
  endfunction

  if (MUXSEQ_BLANKCYCLES > 0) begin : g_cnt
    localparam int CW = $clog2(MUXSEQ_BLANKCYCLES + 1);
    logic cnt_load;
    assign cnt_load = (state == ST_STABLE) && req_valid && (eff_sel != active);
    cc_muxseq_counter #(.WIDTH(CW)) u_cnt (
      .clk        (CC_MUXSEQ_CLOCK_50),
      .rst_n      (CC_MUXSEQ_RESET_InLow),
      .load       (cnt_load),
      .load_value (CW'(MUXSEQ_BLANKCYCLES - 1)),
      .dec        (state == ST_BLANK),
      .zero       (cnt_zero)
    );
  end else begin : g_nocnt
    assign cnt_zero = 1'b1;
  end

  always_ff @(posedge CC_MUXSEQ_CLOCK_50 or negedge CC_MUXSEQ_RESET_InLow) begin
    if (!CC_MUXSEQ_RESET_InLow) begin
      state   <= ST_STABLE;
      active  <= '0;
      pending <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (req_valid && (eff_sel != active)) begin
            if (MUXSEQ_BLANKCYCLES == 0) begin
              active <= eff_sel;
              data_q <= chan(eff_sel);
            end else begin
              pending <= eff_sel;
              data_q  <= MUXSEQ_BLANKVALUE;
              state   <= ST_BLANK;
              busy_q  <= 1'b1;
            end
          end else begin
            data_q <= chan(active);
          end
        end
        ST_BLANK: begin
          pending <= next_pending;
          if (cnt_zero) begin
            active <= next_pending;
            data_q <= chan(next_pending);
            state  <= ST_STABLE;
            busy_q <= 1'b0;
          end else begin
            data_q <= MUXSEQ_BLANKVALUE;
          end
        end
        default: state <= ST_STABLE;
      endcase
    end
  end

`ifdef CC_MUXSEQ_ERRFLAG_EN
  always_ff @(posedge CC_MUXSEQ_CLOCK_50 or negedge CC_MUXSEQ_RESET_InLow) begin
    if (!CC_MUXSEQ_RESET_InLow) begin
      err_q <= 1'b0;
    end else if (CC_MUXSEQ_load_In && !in_range) begin
      err_q <= 1'b1;
    end
  end
`endif

  assign CC_MUXSEQ_data_OutBUS = data_q;
  assign CC_MUXSEQ_sel_OutBUS  = active;
  assign CC_MUXSEQ_busy_Out    = busy_q;

endmodule

// File: tb/tb_cc_muxseq.sv
// tb/tb_cc_muxseq.sv - directed checks of cc_muxseq: 4ch/B=3, 4ch/B=0 and 3ch/B=3 instances
module tb_cc_muxseq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d0, d1;
  logic [23:0] d2;
  logic [1:0]  s0, s1, s2;
  logic        l0, l1, l2;
  logic [7:0]  o0, o1, o2;
  logic [1:0]  q0, q1, q2;
  logic        b0, b1, b2;
`ifdef CC_MUXSEQ_ERRFLAG_EN
  logic        e0, e1, e2;
`endif

  int vectors = 0;
  int errors  = 0;

  cc_muxseq #(.MUXSEQ_CHANNELS(4), .MUXSEQ_BLANKCYCLES(3)) u0 (
    .CC_MUXSEQ_CLOCK_50(clk), .CC_MUXSEQ_RESET_InLow(rst_n),
    .CC_MUXSEQ_data_InBUS(d0), .CC_MUXSEQ_select_InBUS(s0), .CC_MUXSEQ_load_In(l0),
    .CC_MUXSEQ_data_OutBUS(o0), .CC_MUXSEQ_sel_OutBUS(q0), .CC_MUXSEQ_busy_Out(b0)
`ifdef CC_MUXSEQ_ERRFLAG_EN
    , .CC_MUXSEQ_error_Out(e0)
`endif
  );

  cc_muxseq #(.MUXSEQ_CHANNELS(4), .MUXSEQ_BLANKCYCLES(0)) u1 (
    .CC_MUXSEQ_CLOCK_50(clk), .CC_MUXSEQ_RESET_InLow(rst_n),
    .CC_MUXSEQ_data_InBUS(d1), .CC_MUXSEQ_select_InBUS(s1), .CC_MUXSEQ_load_In(l1),
    .CC_MUXSEQ_data_OutBUS(o1), .CC_MUXSEQ_sel_OutBUS(q1), .CC_MUXSEQ_busy_Out(b1)
`ifdef CC_MUXSEQ_ERRFLAG_EN
    , .CC_MUXSEQ_error_Out(e1)
`endif
  );

  cc_muxseq #(.MUXSEQ_CHANNELS(3), .MUXSEQ_BLANKCYCLES(3)) u2 (
    .CC_MUXSEQ_CLOCK_50(clk), .CC_MUXSEQ_RESET_InLow(rst_n),
    .CC_MUXSEQ_data_InBUS(d2), .CC_MUXSEQ_select_InBUS(s2), .CC_MUXSEQ_load_In(l2),
    .CC_MUXSEQ_data_OutBUS(o2), .CC_MUXSEQ_sel_OutBUS(q2), .CC_MUXSEQ_busy_Out(b2)
`ifdef CC_MUXSEQ_ERRFLAG_EN
    , .CC_MUXSEQ_error_Out(e2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [7:0] data, input logic [1:0] sel, input logic busy);
    check({tag, ".data"}, 32'(o0), 32'(data));
    check({tag, ".sel"},  32'(q0), 32'(sel));
    check({tag, ".busy"}, 32'(b0), 32'(busy));
  endtask

  initial begin
    d0 = {8'h44, 8'h33, 8'h22, 8'h11};
    d1 = {8'h44, 8'h33, 8'h22, 8'h11};
    d2 = {8'h33, 8'h22, 8'h11};
    s0 = 2'd0; s1 = 2'd0; s2 = 2'd0;
    l0 = 1'b0; l1 = 1'b0; l2 = 1'b0;

    step(); step();
    chk0("reset", 8'h00, 2'd0, 1'b0);
    check("reset.u1.data", 32'(o1), 32'h0);
`ifdef CC_MUXSEQ_ERRFLAG_EN
    check("reset.u2.err", 32'(e2), 32'h0);
`endif
    rst_n = 1'b1;
    step();
    chk0("release", 8'h11, 2'd0, 1'b0);

    // Switch to channel 2: three blank cycles, then 0x33.
    s0 = 2'd2; l0 = 1'b1;
    step();
    l0 = 1'b0;
    chk0("sw2.blank0", 8'h00, 2'd0, 1'b1);
    for (int i = 1; i < 3; i++) begin
      step();
      chk0($sformatf("sw2.blank%0d", i), 8'h00, 2'd0, 1'b1);
    end
    step();
    chk0("sw2.commit", 8'h33, 2'd2, 1'b0);

    // Last request wins, blank not extended.
    s0 = 2'd1; l0 = 1'b1;
    step();
    s0 = 2'd3;
    step();
    l0 = 1'b0;
    chk0("lastwins.blank1", 8'h00, 2'd2, 1'b1);
    step();
    chk0("lastwins.blank2", 8'h00, 2'd2, 1'b1);
    step();
    chk0("lastwins.commit", 8'h44, 2'd3, 1'b0);

    // Same-channel load is ignored; live data tracks with one cycle latency.
    s0 = 2'd3; l0 = 1'b1; d0[31:24] = 8'h45;
    step();
    l0 = 1'b0;
    chk0("same.noop", 8'h45, 2'd3, 1'b0);

    // Re-request of old active during blank still runs the full blank.
    s0 = 2'd0; l0 = 1'b1;
    step();
    s0 = 2'd3;
    step();
    l0 = 1'b0;
    step();
    chk0("oldactive.blank2", 8'h00, 2'd3, 1'b1);
    step();
    chk0("oldactive.commit", 8'h45, 2'd3, 1'b0);

    // Zero blank cycles: immediate switch, busy never set.
    s1 = 2'd1; l1 = 1'b1;
    step();
    l1 = 1'b0;
    check("b0.data", 32'(o1), 32'h22);
    check("b0.sel",  32'(q1), 32'd1);
    check("b0.busy", 32'(b1), 32'd0);
    d1[15:8] = 8'h23;
    step();
    check("b0.track", 32'(o1), 32'h23);
    check("b0.busy2", 32'(b1), 32'd0);

    // Out-of-range select on a 3-channel instance.
    s2 = 2'd3; l2 = 1'b1;
    step();
    l2 = 1'b0;
`ifdef CC_MUXSEQ_ERRFLAG_EN
    check("oor.err",  32'(e2), 32'd1);
    check("oor.data", 32'(o2), 32'h11);
    check("oor.sel",  32'(q2), 32'd0);
    check("oor.busy", 32'(b2), 32'd0);
    step(); step(); step();
    check("oor.sticky", 32'(e2), 32'd1);
    check("oor.data2",  32'(o2), 32'h11);
`else
    check("oor.blank", 32'(o2), 32'h00);
    check("oor.busy",  32'(b2), 32'd1);
    step(); step();
    check("oor.blank2", 32'(o2), 32'h00);
    step();
    check("oor.data", 32'(o2), 32'h33);
    check("oor.sel",  32'(q2), 32'd2);
    check("oor.idle", 32'(b2), 32'd0);
`endif

    // Bring u0 back to channel 0, then reset during the blank toward channel 3.
    s0 = 2'd0; l0 = 1'b1;
    step();
    l0 = 1'b0;
    step(); step(); step();
    chk0("back0", 8'h11, 2'd0, 1'b0);
    s0 = 2'd3; l0 = 1'b1;
    step();
    l0 = 1'b0;
    step();
    chk0("rstblank.pre", 8'h00, 2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk0("rstblank.async", 8'h00, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk0("rstblank.rel", 8'h11, 2'd0, 1'b0);
    step(); step(); step();
    chk0("rstblank.noswitch", 8'h11, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
